// File: rtl/dispatch_scoreboard_queue.sv
// In-order dispatch queue between fetch and decode. Holds the head instruction
// back while any tracked pipeline stage still has to write one of its sources.
module dispatch_scoreboard_queue #(
    parameter int CORE        = 0,
    parameter int DATA_WIDTH  = 32,
    parameter int QUEUE_DEPTH = 8,
    parameter int INDEX_WIDTH = 3,
    parameter int NUM_STAGES  = 4,
    parameter int REG_WIDTH   = 5
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [DATA_WIDTH-1:0]         in_instruction,
    output logic                          in_ready,
    input  logic [NUM_STAGES-1:0]         stage_valid,
    input  logic [NUM_STAGES*REG_WIDTH-1:0] stage_dest,
    input  logic                          flush,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         out_instruction,
    input  logic                          out_ready,
    output logic [INDEX_WIDTH:0]          occupancy,
    output logic [15:0]                   stall_count,
    input  logic                          report
);

    localparam logic [INDEX_WIDTH:0] DEPTH_CNT = (INDEX_WIDTH+1)'(QUEUE_DEPTH);

    logic [DATA_WIDTH-1:0]  queue_mem [QUEUE_DEPTH];
    logic [INDEX_WIDTH-1:0] head_q, head_d;
    logic [INDEX_WIDTH-1:0] tail_q, tail_d;
    logic [INDEX_WIDTH:0]   count_q, count_d;
    logic [15:0]            stall_q, stall_d;

    logic [DATA_WIDTH-1:0]  head_instr;
    logic [6:0]             opcode;
    logic [REG_WIDTH-1:0]   rs1;
    logic [REG_WIDTH-1:0]   rs2;
    logic                   use_rs1;
    logic                   use_rs2;
    logic [NUM_STAGES-1:0]  stage_hit;
    logic                   hazard;
    logic                   not_empty;
    logic                   push;
    logic                   pop;

    // report and CORE only serve the simulation-side status print.
    logic unused_report;
    assign unused_report = report ^ (CORE != 0);

    assign head_instr = queue_mem[head_q];
    assign opcode     = head_instr[6:0];
    assign rs1        = head_instr[15 +: REG_WIDTH];
    assign rs2        = head_instr[20 +: REG_WIDTH];

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opcode)
            7'b0110011, 7'b0100011, 7'b1100011: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            7'b0010011, 7'b0000011, 7'b1100111: begin
                use_rs1 = 1'b1;
            end
            default: begin
                use_rs1 = 1'b0;
                use_rs2 = 1'b0;
            end
        endcase
    end

    // x0 is hard-wired to zero, so a stage writing it never blocks issue.
    generate
        for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage_cmp
            logic [REG_WIDTH-1:0] dest;
            assign dest = stage_dest[gi*REG_WIDTH +: REG_WIDTH];
            assign stage_hit[gi] = stage_valid[gi] && (dest != '0) &&
                                   ((use_rs1 && (dest == rs1)) ||
                                    (use_rs2 && (dest == rs2)));
        end
    endgenerate

    assign hazard    = |stage_hit;
    assign not_empty = (count_q != '0);

    assign in_ready        = (count_q != DEPTH_CNT);
    assign out_valid       = not_empty & ~hazard & ~flush;
    assign out_instruction = not_empty ? head_instr : '0;
    assign occupancy       = count_q;
    assign stall_count     = stall_q;

    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        stall_d = stall_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                tail_d = tail_q + 1'b1;
            end
            if (pop) begin
                head_d = head_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
        if (not_empty && hazard && !flush && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            stall_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            stall_q <= stall_d;
        end
    end

    // Storage is not reset; stale entries stay hidden behind count_q.
    always_ff @(posedge clock) begin
        if (push) begin
            queue_mem[tail_q] <= in_instruction;
        end
    end

endmodule

// File: tb/tb_dispatch_scoreboard_queue.sv
// Bench for dispatch_scoreboard_queue: hazard vector table, fill/overflow,
// wrap-around scoreboard, flush collision and asynchronous reset.
module tb_dispatch_scoreboard_queue;

    localparam int QD = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_instruction;
    logic        in_ready;
    logic [3:0]  stage_valid;
    logic [19:0] stage_dest;
    logic        flush;
    logic        out_valid;
    logic [31:0] out_instruction;
    logic        out_ready;
    logic [3:0]  occupancy;
    logic [15:0] stall_count;
    logic        report;

    dispatch_scoreboard_queue #(
        .CORE(0), .DATA_WIDTH(32), .QUEUE_DEPTH(8), .INDEX_WIDTH(3),
        .NUM_STAGES(4), .REG_WIDTH(5)
    ) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_instruction(in_instruction), .in_ready(in_ready),
        .stage_valid(stage_valid), .stage_dest(stage_dest), .flush(flush),
        .out_valid(out_valid), .out_instruction(out_instruction), .out_ready(out_ready),
        .occupancy(occupancy), .stall_count(stall_count), .report(report)
    );

    always #5 clock = ~clock;

    int compared   = 0;
    int mismatched = 0;
    int exp_stall  = 0;
    logic [31:0] sb[$];

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  sv;
        logic [19:0] dest;
        logic        hazard;
    } vec_t;
    vec_t vecs[15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s = 0x%0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One clock of plain queue traffic with no hazards, checked against the scoreboard.
    task automatic cycle(input logic iv, input logic [31:0] ins, input logic ordy);
        logic accept;
        logic [31:0] exp_ins;
        in_valid = iv; in_instruction = ins; out_ready = ordy;
        flush = 1'b0; stage_valid = '0; stage_dest = '0;
        #1;
        accept = iv && (sb.size() < QD);
        check("in_ready", in_ready, sb.size() != QD);
        check("out_valid", out_valid, sb.size() != 0);
        if (sb.size() != 0) begin
            exp_ins = sb[0];
            check("out_instruction", out_instruction, exp_ins);
            if (ordy) void'(sb.pop_front());
        end else begin
            check("empty_out_instruction", out_instruction, 0);
        end
        if (accept) sb.push_back(ins);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        check("occupancy", occupancy, sb.size());
    endtask

    initial begin
        // instr, stage_valid, stage_dest {WB,MEM,EXE,ID}, hazard
        vecs[0]  = '{32'h002081B3, 4'b0010, 20'h00020, 1'b1}; // add: EXE writes x1
        vecs[1]  = '{32'h002081B3, 4'b0000, 20'h00020, 1'b0}; // stage not valid
        vecs[2]  = '{32'h002081B3, 4'b1000, 20'h10000, 1'b1}; // WB writes x2 (rs2)
        vecs[3]  = '{32'h002081B3, 4'b0001, 20'h00003, 1'b0}; // ID writes x3 = rd only
        vecs[4]  = '{32'h000001B7, 4'b1111, 20'h08421, 1'b0}; // lui: no sources
        vecs[5]  = '{32'h00500193, 4'b0001, 20'h00000, 1'b0}; // rs1=x0, dest x0
        vecs[6]  = '{32'h00508193, 4'b0100, 20'h01400, 1'b0}; // addi: rs2 field unused
        vecs[7]  = '{32'h00508193, 4'b0100, 20'h00400, 1'b1}; // addi: MEM writes rs1
        vecs[8]  = '{32'h0020A023, 4'b0010, 20'h00040, 1'b1}; // sw: rs2 hazard
        vecs[9]  = '{32'h00208063, 4'b0001, 20'h00002, 1'b1}; // beq: rs2 hazard
        vecs[10] = '{32'h0000806F, 4'b0001, 20'h00001, 1'b0}; // jal: no sources
        vecs[11] = '{32'h00008067, 4'b0001, 20'h00001, 1'b1}; // jalr: rs1 hazard
        vecs[12] = '{32'h0000A183, 4'b0001, 20'h00001, 1'b1}; // lw: rs1 hazard
        vecs[13] = '{32'h00008197, 4'b0001, 20'h00001, 1'b0}; // auipc: no sources
        vecs[14] = '{32'h0000807F, 4'b0001, 20'h00001, 1'b0}; // unknown opcode

        reset = 1'b0; in_valid = 1'b0; in_instruction = '0; stage_valid = '0;
        stage_dest = '0; flush = 1'b0; out_ready = 1'b0; report = 1'b0;
        #2;
        check("rst_occupancy", occupancy, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_instruction", out_instruction, 0);
        check("rst_stall_count", stall_count, 0);
        tick(); tick();
        reset = 1'b1;

        // Hazard decode table: one entry at a time, flushed afterwards.
        for (int i = 0; i < 15; i++) begin
            in_valid = 1'b1; in_instruction = vecs[i].instr; stage_valid = '0;
            tick();
            in_valid = 1'b0;
            stage_valid = vecs[i].sv; stage_dest = vecs[i].dest;
            #1;
            check($sformatf("vec%0d_out_valid", i), out_valid, !vecs[i].hazard);
            check($sformatf("vec%0d_out_instruction", i), out_instruction, vecs[i].instr);
            tick();
            if (vecs[i].hazard) exp_stall++;
            check($sformatf("vec%0d_stall_count", i), stall_count, exp_stall);
            flush = 1'b1;
            tick();
            flush = 1'b0; stage_valid = '0; stage_dest = '0;
            check($sformatf("vec%0d_flushed", i), occupancy, 0);
            check($sformatf("vec%0d_stall_kept", i), stall_count, exp_stall);
        end

        // Sustained RAW stall, then release.
        in_valid = 1'b1; in_instruction = 32'h002081B3;
        tick();
        in_valid = 1'b0; stage_valid = 4'b0010; stage_dest = 20'h00020;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("raw%0d_out_valid", c), out_valid, 0);
            tick();
            exp_stall++;
            check($sformatf("raw%0d_stall_count", c), stall_count, exp_stall);
        end
        stage_valid = '0;
        #1;
        check("raw_release_out_valid", out_valid, 1);
        check("raw_release_out_instruction", out_instruction, 32'h002081B3);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("raw_popped_occupancy", occupancy, 0);
        check("raw_stall_frozen", stall_count, exp_stall);

        // Fill to full, overflow attempt, drain.
        for (int i = 0; i < QD; i++) cycle(1'b1, 32'h00000013, 1'b0);
        check("full_in_ready", in_ready, 0);
        cycle(1'b1, 32'hDEADBEEF, 1'b0);
        check("overflow_occupancy", occupancy, 8);
        for (int i = 0; i < QD; i++) cycle(1'b0, 32'h0, 1'b1);

        // Wrap-around streaming.
        for (int i = 0; i < 20; i++) cycle(1'b1, 32'h00001000 + i, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);
        check("wrap_drained", sb.size(), 0);

        // Flush colliding with push and pop.
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'h000000A0 + i, 1'b0);
        check("pre_flush_occupancy", occupancy, 5);
        flush = 1'b1; in_valid = 1'b1; in_instruction = 32'h00000BAD; out_ready = 1'b1;
        #1;
        check("flush_cycle_out_valid", out_valid, 0);
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        sb.delete();
        check("post_flush_occupancy", occupancy, 0);
        check("post_flush_out_valid", out_valid, 0);
        check("post_flush_out_instruction", out_instruction, 0);
        check("post_flush_stall_count", stall_count, exp_stall);
        cycle(1'b0, 32'h0, 1'b1);

        // Asynchronous reset between edges.
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h00000013, 1'b0);
        check("pre_reset_occupancy", occupancy, 3);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_occupancy", occupancy, 0);
        check("async_rst_stall_count", stall_count, 0);
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_in_ready", in_ready, 1);
        check("async_rst_out_instruction", out_instruction, 0);
        #3;
        reset = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dispatch_scoreboard_queue.md
Name: dispatch_scoreboard_queue

Overview:
- Parametrised in-order instruction dispatch queue with a RAW-hazard scoreboard.
- Buffers fetched instructions in a circular queue and compares the head instruction's source registers against the destinations of in-flight pipeline stages (ID/EXE/MEM/WB by default).
- Issues the head to decode only when no hazard exists and downstream is ready.
- Sits between fetch and decode in each core; generalises queue depth and stage count, and adds handshakes, flush and stall statistics.

Parameters:
- CORE, 0, core index; used only for report output.
- DATA_WIDTH, 32, instruction width; must be ≥32, with RV32 field positions fixed.
- QUEUE_DEPTH, 8, number of queue entries; power of two, ≥2.
- INDEX_WIDTH, 3, log2(QUEUE_DEPTH).
- NUM_STAGES, 4, number of tracked in-flight stages; stage 0 = ID.
- REG_WIDTH, 5, register address width.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetch presents an instruction.
- in_instruction  in  DATA_WIDTH  instruction to enqueue.
- in_ready  out  1  queue can accept (= not full).
- stage_valid  in  NUM_STAGES  stage i holds a register-writing instruction.
- stage_dest  in  NUM_STAGES*REG_WIDTH  stage i rd at bits [i*REG_WIDTH +: REG_WIDTH].
- flush  in  1  synchronous queue discard (branch redirect).
- out_valid  out  1  head is issuable.
- out_instruction  out  DATA_WIDTH  head entry.
- out_ready  in  1  decode accepts.
- occupancy  out  INDEX_WIDTH+1  current entry count.
- stall_count  out  16  saturating count of hazard-stall cycles.
- report  in  1  when high at a clock edge, simulation prints CORE, occupancy and stall_count.

Behaviour:
- Reset (reset=0, asynchronous):
  - head, tail and count are cleared; occupancy=0 and stall_count=0.
  - in_ready=1 and out_valid=0.
  - out_instruction=0 (driven as 0 whenever the queue is empty).
- Push: in_valid & in_ready at the edge writes in_instruction at tail; tail increments modulo QUEUE_DEPTH.
- Pop: out_valid & out_ready at the edge increments head modulo QUEUE_DEPTH.
- Simultaneous push and pop:
  - Both take effect and count is unchanged.
  - When full, in_ready=0, so the push is not taken even if a pop occurs in the same cycle.
- in_ready = (count != QUEUE_DEPTH); combinational from registered count only.
- Head decode, all combinational:
  - opcode = [6:0], rs1 = [19:15], rs2 = [24:20].
  - Source use by opcode:
    - 0110011, 0100011, 1100011: rs1 and rs2.
    - 0010011, 0000011, 1100111: rs1 only.
    - 0110111, 0010111, 1101111, and any other opcode: no sources.
- Hazard: some stage i has stage_valid[i]=1, stage_dest_i != 0, and stage_dest_i equals a used source. Register x0 never hazards.
- out_valid = (count != 0) & ~hazard & ~flush.
  - Issue latency: an instruction pushed at edge N may issue in the cycle after edge N (one-cycle minimum through the queue; no bypass).
- stall_count increments by 1 on each edge where count != 0, hazard = 1 and flush = 0. It saturates at 0xFFFF.
- Flush:
  - At the edge, head, tail and count are cleared; any push or pop in that cycle is discarded.
  - out_valid is forced low during the flush cycle.
  - stall_count is retained.
- Wrap-around: pointers are INDEX_WIDTH wide and wrap naturally; full or empty is determined by count, never by pointer equality.
- Reset asserted mid-operation:
  - Queue contents are lost; entries need not be cleared, but their outputs are masked by count=0.
  - Outputs reach reset values immediately, without waiting for a clock.

Test Plan:
- Reset then fill: push 8 instructions 0x00000013 with no stages valid. After 8 edges, occupancy=8 and in_ready=0. A 9th push is ignored: occupancy stays 8 and the entry is not written.
- RAW stall: push 0x002081B3 (add x3,x1,x2) with stage_valid=4'b0010 and stage_dest EXE=1. Required: out_valid=0 and stall_count increments each cycle. Dropping stage_valid gives out_valid=1 and out_instruction=0x002081B3.
- No false hazard: head 0x000001B7 (lui x3) with all stages valid at dest=1 gives out_valid=1. Head with rs1=0 and a stage dest of 0 gives out_valid=1.
- Wrap-around: 20 push/pop pairs with out_ready=1 and an incrementing payload. Outputs emerge in order, occupancy stays ≤1, and pointers wrap past 7 correctly.
- Flush collision: occupancy=5, then flush with in_valid=1 and out_ready=1 in the same cycle. Required: occupancy=0 next cycle, out_valid=0, and no push or issue recorded.
- Async reset mid-run: drive reset low between edges at occupancy=3. Required: occupancy=0, stall_count=0 and out_valid=0 before the next edge.
